// File: rtl/vend_change_dispenser_if.sv
// Change-request and hopper signal bundle between the vending FSM / hopper drivers and the dispenser.
interface vend_change_dispenser_if #(
  parameter int unsigned AMT_W = 5
);
  logic             change_valid;
  logic [AMT_W-1:0] change_amt;
  logic             N_empty;
  logic             D_empty;
  logic             Q_empty;
  logic             N_out;
  logic             D_out;
  logic             Q_out;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] rem_amt;

  modport master (
    output change_valid, change_amt, N_empty, D_empty, Q_empty,
    input  N_out, D_out, Q_out, busy, done, fault, rem_amt
  );

  modport slave (
    input  change_valid, change_amt, N_empty, D_empty, Q_empty,
    output N_out, D_out, Q_out, busy, done, fault, rem_amt
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// Coin-return hopper sequencer: pays a nickel-unit change amount greedily (Q, D, N),
// skipping empty hoppers, one coin pulse per GAP_CYCLES+2 cycles.
module vend_change_dispenser #(
  parameter int unsigned AMT_W      = 5,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  vend_change_dispenser_if.slave   bus
);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE, S_FAULT
  } state_e;

  typedef enum logic [1:0] {COIN_N, COIN_D, COIN_Q} coin_e;

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             n_out_q, n_out_d;
  logic             d_out_q, d_out_d;
  logic             q_out_q, q_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [AMT_W-1:0] coin_val;

  // Value of the coin currently being ejected, in nickel units
  always_comb begin
    coin_val = AMT_W'(1);
    case (coin_q)
      COIN_Q:  coin_val = AMT_W'(5);
      COIN_D:  coin_val = AMT_W'(2);
      default: coin_val = AMT_W'(1);
    endcase
  end

  // Next-state logic; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d   = state_q;
    coin_d    = coin_q;
    rem_d     = rem_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.change_valid) begin
          rem_d   = bus.change_amt;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else if (rem_q >= AMT_W'(5) && !bus.Q_empty) begin
          coin_d  = COIN_Q;
          state_d = S_PULSE;
        end else if (rem_q >= AMT_W'(2) && !bus.D_empty) begin
          coin_d  = COIN_D;
          state_d = S_PULSE;
        end else if (!bus.N_empty) begin
          coin_d  = COIN_N;
          state_d = S_PULSE;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_PULSE: begin
        rem_d     = rem_q - coin_val;
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_SELECT;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    n_out_d = (state_d == S_PULSE) && (coin_d == COIN_N);
    d_out_d = (state_d == S_PULSE) && (coin_d == COIN_D);
    q_out_d = (state_d == S_PULSE) && (coin_d == COIN_Q);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      coin_q    <= COIN_N;
      rem_q     <= '0;
      gap_cnt_q <= '0;
      n_out_q   <= 1'b0;
      d_out_q   <= 1'b0;
      q_out_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      coin_q    <= coin_d;
      rem_q     <= rem_d;
      gap_cnt_q <= gap_cnt_d;
      n_out_q   <= n_out_d;
      d_out_q   <= d_out_d;
      q_out_q   <= q_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.N_out   = n_out_q;
  assign bus.D_out   = d_out_q;
  assign bus.Q_out   = q_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.rem_amt = rem_q;
endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser: per-cycle output traces compared to hand-derived masks.
module tb_vend_change_dispenser;
  localparam int unsigned AMT_W = 5;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0]      q_tr, d_tr, n_tr, done_tr, busy_tr, fault_tr;
  logic [AMT_W-1:0] rem_tr [0:31];

  vend_change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  vend_change_dispenser #(.AMT_W(AMT_W), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Raise valid in cycle T, then record outputs for cycles T+1..T+ncyc (bit i = cycle T+i).
  // Optional second request at cycle xv_at and reset pulse at cycle rst_at (0 disables).
  task automatic run_req(input logic [AMT_W-1:0] amt, input int ncyc,
                         input int xv_at, input logic [AMT_W-1:0] xv_amt,
                         input int rst_at);
    q_tr = '0; d_tr = '0; n_tr = '0; done_tr = '0; busy_tr = '0; fault_tr = '0;
    for (int k = 0; k < 32; k++) rem_tr[k] = '0;
    bus.change_valid = 1'b1;
    bus.change_amt   = amt;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      q_tr[i]     = bus.Q_out;
      d_tr[i]     = bus.D_out;
      n_tr[i]     = bus.N_out;
      done_tr[i]  = bus.done;
      busy_tr[i]  = bus.busy;
      fault_tr[i] = bus.fault;
      rem_tr[i]   = bus.rem_amt;
      if (i == 1) bus.change_valid = 1'b0;
      if (i == xv_at) begin
        bus.change_valid = 1'b1;
        bus.change_amt   = xv_amt;
      end
      if (i == xv_at + 1) bus.change_valid = 1'b0;
      if (i == rst_at) reset = 1'b1;
      if (i == rst_at + 1) reset = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.change_valid = 1'b0;
    bus.change_amt   = '0;
    bus.N_empty = 1'b0;
    bus.D_empty = 1'b0;
    bus.Q_empty = 1'b0;
    idle(2);
    chk("rst_busy",  32'(bus.busy),    32'd0);
    chk("rst_done",  32'(bus.done),    32'd0);
    chk("rst_fault", 32'(bus.fault),   32'd0);
    chk("rst_coins", 32'({bus.N_out, bus.D_out, bus.Q_out}), 32'd0);
    chk("rst_rem",   32'(bus.rem_amt), 32'd0);
    reset = 1'b0;
    idle(2);

    // amt=7, full hoppers: Q@2, D@6, done@10
    run_req(5'd7, 12, 0, 5'd0, 0);
    chk("a7_q",    q_tr,    32'h0000_0004);
    chk("a7_d",    d_tr,    32'h0000_0040);
    chk("a7_n",    n_tr,    32'h0);
    chk("a7_done", done_tr, 32'h0000_0400);
    chk("a7_busy", busy_tr, 32'h0000_07FE);
    chk("a7_rem1", 32'(rem_tr[1]),  32'd7);
    chk("a7_rem3", 32'(rem_tr[3]),  32'd2);
    chk("a7_rem11", 32'(rem_tr[11]), 32'd0);
    idle(2);

    // amt=0: immediate done
    run_req(5'd0, 4, 0, 5'd0, 0);
    chk("a0_coins", q_tr | d_tr | n_tr, 32'h0);
    chk("a0_done",  done_tr, 32'h0000_0004);
    chk("a0_busy",  busy_tr, 32'h0000_0006);
    idle(2);

    // amt=6 with quarters empty: three dimes
    bus.Q_empty = 1'b1;
    run_req(5'd6, 16, 0, 5'd0, 0);
    chk("a6_d",    d_tr,    32'h0000_0444);
    chk("a6_qn",   q_tr | n_tr, 32'h0);
    chk("a6_done", done_tr, 32'h0000_4000);
    chk("a6_busy", busy_tr, 32'h0000_7FFE);
    chk("a6_rem2", 32'(rem_tr[2]),  32'd6);
    chk("a6_rem3", 32'(rem_tr[3]),  32'd4);
    chk("a6_rem7", 32'(rem_tr[7]),  32'd2);
    chk("a6_rem11", 32'(rem_tr[11]), 32'd0);
    bus.Q_empty = 1'b0;
    idle(2);

    // amt=2 with dimes empty: two nickels
    bus.D_empty = 1'b1;
    run_req(5'd2, 12, 0, 5'd0, 0);
    chk("a2_n",    n_tr,    32'h0000_0044);
    chk("a2_qd",   q_tr | d_tr, 32'h0);
    chk("a2_done", done_tr, 32'h0000_0400);
    bus.D_empty = 1'b0;
    idle(2);

    // amt=3 with nickels empty: one dime, then sticky fault with rem=1
    bus.N_empty = 1'b1;
    run_req(5'd3, 10, 0, 5'd0, 0);
    chk("a3_d",     d_tr,     32'h0000_0004);
    chk("a3_fault", fault_tr, 32'h0000_07C0);
    chk("a3_done",  done_tr,  32'h0);
    chk("a3_busy",  busy_tr,  32'h0000_07FE);
    chk("a3_rem",   32'(rem_tr[10]), 32'd1);
    bus.N_empty = 1'b0;
    idle(5);
    chk("a3_fault_sticky", 32'(bus.fault), 32'd1);
    chk("a3_rem_frozen",   32'(bus.rem_amt), 32'd1);
    chk("a3_no_pulse", 32'({bus.N_out, bus.D_out, bus.Q_out}), 32'd0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("a3_fault_clr", 32'(bus.fault), 32'd0);
    chk("a3_busy_clr",  32'(bus.busy),  32'd0);
    idle(2);

    // amt=5, reset during the Q pulse aborts the request
    run_req(5'd5, 10, 0, 5'd0, 2);
    chk("ab_q",     q_tr,    32'h0000_0004);
    chk("ab_dn",    d_tr | n_tr, 32'h0);
    chk("ab_busy",  busy_tr, 32'h0000_0006);
    chk("ab_done",  done_tr, 32'h0);
    chk("ab_rem3",  32'(rem_tr[3]), 32'd0);
    idle(2);

    // amt=7, second request while busy is ignored
    run_req(5'd7, 14, 3, 5'd2, 0);
    chk("ig_q",    q_tr,    32'h0000_0004);
    chk("ig_d",    d_tr,    32'h0000_0040);
    chk("ig_n",    n_tr,    32'h0);
    chk("ig_done", done_tr, 32'h0000_0400);
    chk("ig_busy", busy_tr, 32'h0000_07FE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
